// File: rtl/fifo_stream_drain_pkg.sv
// Shared types for the FIFO stream drain: buffer occupancy encodings and
// the stored entry width. Optional macro: DRAIN_PARITY_EN (adds a parity bit per entry).
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_e;

    // Bits held per buffer entry: the data word, plus its parity when enabled.
    function automatic int entry_width(input int dw);
`ifdef DRAIN_PARITY_EN
        return dw + 1;
`else
        return dw;
`endif
    endfunction

endpackage

// File: rtl/fifo_stream_drain_if.sv
// Handshake bundle for the drain: FIFO read side and valid/ready stream side.
// Optional macro: DRAIN_PARITY_EN (adds m_parity).
interface fifo_stream_drain_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  fifo_rd;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
`ifdef DRAIN_PARITY_EN
    logic                  m_parity;
`endif

    // Drain side: pops the FIFO and sources the stream.
    modport master (
`ifdef DRAIN_PARITY_EN
        output m_parity,
`endif
        output fifo_rd, m_valid, m_data, m_last,
        input  fifo_empty, fifo_r_data, m_ready
    );

    // Environment side: FIFO plus downstream consumer.
    modport slave (
`ifdef DRAIN_PARITY_EN
        input  m_parity,
`endif
        input  fifo_rd, m_valid, m_data, m_last,
        output fifo_empty, fifo_r_data, m_ready
    );
endinterface

// File: rtl/fifo_stream_drain_skid_buf2.sv
// Two-entry skid buffer. e0 is the head and is presented downstream; e1
// absorbs the word in flight when the consumer stalls. The caller never
// pushes when full nor pops when empty.
import fifo_drain_pkg::*;

module skid_buf2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output cnt_e         count,
    output logic [W-1:0] e0
);
    cnt_e         cnt_q, cnt_d;
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;

    // State registers; async active-low reset empties and zeroes both entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CNT_EMPTY;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    // Next state: clear wins, otherwise fill/shift according to push and pop.
    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        if (clear) begin
            cnt_d = CNT_EMPTY;
            e0_d  = '0;
            e1_d  = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == CNT_EMPTY) begin
                        e0_d  = din;
                        cnt_d = CNT_ONE;
                    end else begin
                        e1_d  = din;
                        cnt_d = CNT_FULL;
                    end
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = (cnt_q == CNT_FULL) ? CNT_ONE : CNT_EMPTY;
                end
                2'b11: begin
                    // Occupancy unchanged; with one entry the new word becomes head.
                    if (cnt_q == CNT_FULL) begin
                        e0_d = e1_q;
                        e1_d = din;
                    end else begin
                        e0_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count = cnt_q;
    assign e0    = e0_q;
endmodule

// File: rtl/fifo_stream_drain.sv
// Pops narrow words from the width-converting FIFO and streams them out as
// fixed-length packets. fifo_rd depends only on registered occupancy, never
// on m_ready, so there is no combinational path from downstream to the FIFO.
// Optional macro: DRAIN_PARITY_EN (stores and outputs even parity per word).
import fifo_drain_pkg::*;

module fifo_stream_drain #(
    parameter int DATA_WIDTH = 4,
    parameter int PKT_LEN    = 8,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    fifo_stream_drain_if.master bus
);
    localparam int                   EW        = entry_width(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

    cnt_e                 count;
    logic [EW-1:0]        din, e0;
    logic                 push, pop, valid;
    logic [CNT_WIDTH-1:0] beat_q, beat_d;

    // Parity is computed once at capture so the output path is a plain flop.
`ifdef DRAIN_PARITY_EN
    assign din          = {^bus.fifo_r_data, bus.fifo_r_data};
    assign bus.m_parity = e0[DATA_WIDTH];
`else
    assign din = bus.fifo_r_data;
`endif

    // Reset gating keeps the FIFO untouched while the drain is held in reset.
    assign valid       = (count != CNT_EMPTY);
    assign push        = reset & ~bus.fifo_empty & (count != CNT_FULL) & ~clear;
    assign pop         = valid & bus.m_ready & ~clear;
    assign bus.fifo_rd = push;
    assign bus.m_valid = valid;
    assign bus.m_data  = e0[DATA_WIDTH-1:0];
    assign bus.m_last  = valid & (beat_q == LAST_BEAT);

    skid_buf2 #(.W(EW)) u_buf (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .count (count),
        .e0    (e0)
    );

    // Beat counter register; position of the head word inside its packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) beat_q <= '0;
        else        beat_q <= beat_d;
    end

    // Advance on each accepted word, wrap after the last beat; clear restarts.
    always_comb begin
        beat_d = beat_q;
        if (clear)    beat_d = '0;
        else if (pop) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end
endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain with a behavioural FIFO in front.
// Optional macro: DRAIN_PARITY_EN (enables the parity scenario).
module tb_fifo_stream_drain;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [3:0] mem [0:4095];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    fifo_stream_drain_if #(.DATA_WIDTH(4)) ifc ();

    fifo_stream_drain #(.DATA_WIDTH(4), .PKT_LEN(8), .CNT_WIDTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    assign ifc.fifo_empty  = (rd_ptr == wr_ptr);
    assign ifc.fifo_r_data = mem[rd_ptr[11:0]];

    always @(posedge clk) if (ifc.fifo_rd) rd_ptr <= rd_ptr + 1;

    task automatic fpush(input logic [3:0] v);
        mem[wr_ptr[11:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        ifc.m_ready = 1'b0;
        fpush(4'h5);
        #1;
        n_cmp += 4;
        if (ifc.m_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", ifc.m_valid); end
        if (ifc.m_data !== 4'h0) begin n_err++; $display("FAIL rst_data got %h exp 0", ifc.m_data); end
        if (ifc.m_last !== 1'b0) begin n_err++; $display("FAIL rst_last got %b exp 0", ifc.m_last); end
        if (ifc.fifo_rd !== 1'b0) begin n_err++; $display("FAIL rst_rd got %b exp 0", ifc.fifo_rd); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (ifc.m_valid !== 1'b1) begin n_err++; $display("FAIL rst_first_valid got %b exp 1", ifc.m_valid); end
        if (ifc.m_data !== 4'h5) begin n_err++; $display("FAIL rst_first_data got %h exp 5", ifc.m_data); end
        ifc.m_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ifc.m_valid !== 1'b0) begin n_err++; $display("FAIL rst_drained got %b exp 0", ifc.m_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        ifc.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fpush(4'(i));
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_cmp += 3;
            if (ifc.m_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b exp 1", i, ifc.m_valid); end
            if (ifc.m_data !== 4'(i)) begin n_err++; $display("FAIL stream_data[%0d] got %h exp %h", i, ifc.m_data, 4'(i)); end
            if (ifc.m_last !== (i == 8)) begin n_err++; $display("FAIL stream_last[%0d] got %b exp %b", i, ifc.m_last, i == 8); end
        end
        @(negedge clk);
        n_cmp++;
        if (ifc.m_valid !== 1'b0) begin n_err++; $display("FAIL stream_idle got %b exp 0", ifc.m_valid); end
    endtask

    task automatic test_backpressure();
        logic [3:0] ex [4];
        int base;
        ex = '{4'hA, 4'hB, 4'hC, 4'hD};
        do_reset();
        ifc.m_ready = 1'b0;
        base = rd_ptr;
        for (int k = 0; k < 4; k++) fpush(ex[k]);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp += 4;
            if (ifc.m_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b exp 1", c, ifc.m_valid); end
            if (ifc.m_data !== 4'hA) begin n_err++; $display("FAIL bp_hold[%0d] got %h exp a", c, ifc.m_data); end
            if (ifc.fifo_rd !== 1'b0) begin n_err++; $display("FAIL bp_rd[%0d] got %b exp 0", c, ifc.fifo_rd); end
            if (rd_ptr - base != 2) begin n_err++; $display("FAIL bp_pops[%0d] got %0d exp 2", c, rd_ptr - base); end
        end
        ifc.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp += 3;
            if (ifc.m_valid !== 1'b1) begin n_err++; $display("FAIL bp_rel_valid[%0d] got %b exp 1", k, ifc.m_valid); end
            if (ifc.m_data !== ex[k]) begin n_err++; $display("FAIL bp_rel_data[%0d] got %h exp %h", k, ifc.m_data, ex[k]); end
            if (ifc.m_last !== 1'b0) begin n_err++; $display("FAIL bp_rel_last[%0d] got %b exp 0", k, ifc.m_last); end
            @(negedge clk);
        end
        n_cmp++;
        if (ifc.m_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle got %b exp 0", ifc.m_valid); end
    endtask

    task automatic test_random();
        int base, pushed, idx, cyc;
        do_reset();
        base = wr_ptr; pushed = 0; idx = 0; cyc = 0;
        while (idx < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                fpush(4'($urandom));
                pushed++;
            end
            ifc.m_ready = ($urandom_range(0, 1) == 1);
            if (ifc.m_valid && ifc.m_ready) begin
                n_cmp += 2;
                if (ifc.m_data !== mem[(base + idx) % 4096]) begin
                    n_err++; $display("FAIL rand_data[%0d] got %h exp %h", idx, ifc.m_data, mem[(base + idx) % 4096]);
                end
                if (ifc.m_last !== (idx % 8 == 7)) begin
                    n_err++; $display("FAIL rand_last[%0d] got %b exp %b", idx, ifc.m_last, idx % 8 == 7);
                end
                idx++;
            end
        end
        n_cmp++;
        if (idx != 1000) begin n_err++; $display("FAIL rand_timeout got %0d words exp 1000", idx); end
        ifc.m_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clear();
        logic [3:0] ex [8];
        ex = '{4'hB, 4'hC, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        do_reset();
        ifc.m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) fpush(4'(i));
        repeat (7) @(negedge clk);
        ifc.m_ready = 1'b0;
        fpush(4'h9); fpush(4'hA); fpush(4'hB); fpush(4'hC);
        repeat (4) @(negedge clk);
        n_cmp += 3;
        if (ifc.m_valid !== 1'b1) begin n_err++; $display("FAIL clr_pre_valid got %b exp 1", ifc.m_valid); end
        if (ifc.m_data !== 4'h9) begin n_err++; $display("FAIL clr_pre_data got %h exp 9", ifc.m_data); end
        if (ifc.fifo_rd !== 1'b0) begin n_err++; $display("FAIL clr_pre_rd got %b exp 0", ifc.fifo_rd); end
        clear = 1'b1;
        ifc.m_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (ifc.m_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got %b exp 0", ifc.m_valid); end
        for (int i = 1; i <= 6; i++) fpush(4'(i));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp += 3;
            if (ifc.m_valid !== 1'b1) begin n_err++; $display("FAIL clr_valid[%0d] got %b exp 1", k, ifc.m_valid); end
            if (ifc.m_data !== ex[k]) begin n_err++; $display("FAIL clr_data[%0d] got %h exp %h", k, ifc.m_data, ex[k]); end
            if (ifc.m_last !== (k == 7)) begin n_err++; $display("FAIL clr_last[%0d] got %b exp %b", k, ifc.m_last, k == 7); end
        end
        @(negedge clk);
        n_cmp++;
        if (ifc.m_valid !== 1'b0) begin n_err++; $display("FAIL clr_idle got %b exp 0", ifc.m_valid); end
    endtask

    task automatic test_midreset();
        do_reset();
        ifc.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fpush(4'(i));
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ifc.m_data !== 4'h3) begin n_err++; $display("FAIL mrst_pre got %h exp 3", ifc.m_data); end
        #2 reset = 1'b0;
        #1;
        n_cmp += 4;
        if (ifc.m_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b exp 0", ifc.m_valid); end
        if (ifc.m_data !== 4'h0) begin n_err++; $display("FAIL mrst_data got %h exp 0", ifc.m_data); end
        if (ifc.m_last !== 1'b0) begin n_err++; $display("FAIL mrst_last got %b exp 0", ifc.m_last); end
        if (ifc.fifo_rd !== 1'b0) begin n_err++; $display("FAIL mrst_rd got %b exp 0", ifc.fifo_rd); end
        @(negedge clk);
        n_cmp++;
        if (ifc.m_valid !== 1'b0) begin n_err++; $display("FAIL mrst_hold got %b exp 0", ifc.m_valid); end
        reset = 1'b1;
        fpush(4'h9); fpush(4'hA); fpush(4'hB);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp += 3;
            if (ifc.m_valid !== 1'b1) begin n_err++; $display("FAIL mrst_valid[%0d] got %b exp 1", k, ifc.m_valid); end
            if (ifc.m_data !== 4'(k + 4)) begin n_err++; $display("FAIL mrst_data[%0d] got %h exp %h", k, ifc.m_data, 4'(k + 4)); end
            if (ifc.m_last !== (k == 7)) begin n_err++; $display("FAIL mrst_last[%0d] got %b exp %b", k, ifc.m_last, k == 7); end
        end
        @(negedge clk);
        n_cmp++;
        if (ifc.m_valid !== 1'b0) begin n_err++; $display("FAIL mrst_idle got %b exp 0", ifc.m_valid); end
    endtask

`ifdef DRAIN_PARITY_EN
    task automatic test_parity();
        do_reset();
        ifc.m_ready = 1'b1;
        fpush(4'h7); fpush(4'h3);
        @(negedge clk);
        n_cmp += 2;
        if (ifc.m_data !== 4'h7) begin n_err++; $display("FAIL par_data0 got %h exp 7", ifc.m_data); end
        if (ifc.m_parity !== 1'b1) begin n_err++; $display("FAIL par_7 got %b exp 1", ifc.m_parity); end
        @(negedge clk);
        n_cmp += 2;
        if (ifc.m_data !== 4'h3) begin n_err++; $display("FAIL par_data1 got %h exp 3", ifc.m_data); end
        if (ifc.m_parity !== 1'b0) begin n_err++; $display("FAIL par_3 got %b exp 0", ifc.m_parity); end
        @(negedge clk);
    endtask
`endif

    initial begin
        ifc.m_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_clear();
        test_midreset();
`ifdef DRAIN_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
